// File: rtl/result_reader.sv
// result_reader: reads the M x T result matrix back from the 16 x 64-bit output
// SRAM and streams it to the host, row-major, over a valid/ready interface.
// Each SRAM word carries four 16-bit elements; column 0 is the MSB slice.
// Optional build macro RESULT_READER_PREFETCH_EN: double-buffers the SRAM word and
// issues the next read while the last element of the current word is on the
// bus, removing the per-word bubbles.
module result_reader #(
  parameter int ELEM_W  = 16,
  parameter int WORD_W  = 64,
  parameter int ADDR_W  = 4,
  parameter int MAX_DIM = 8
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic [11:0]       MNT,
  input  logic              START,
  output logic              EN_O,
  output logic              RW_O,
  output logic [ADDR_W-1:0] ADDR_O,
  input  logic [WORD_W-1:0] RDATA_O,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [ELEM_W-1:0] OUT_DATA,
  output logic              OUT_LAST,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SKIP,
    S_RD,
    S_WT,
    S_SEND,
    S_FIN
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [3:0]        r_m;
  logic [3:0]        r_t;
  logic [3:0]        r_row;
  logic [3:0]        r_col;

  logic [3:0]        w_m_clamp;
  logic [3:0]        w_t_clamp;
  logic              w_hs;
  logic              w_row_end;
  logic              w_word_end;
  logic              w_last;
  logic [WORD_W-1:0] w_word;
  logic [ELEM_W-1:0] w_elem;
  logic              w_unused_n;

`ifdef RESULT_READER_PREFETCH_EN
  logic [WORD_W-1:0] r_buf [2];
  logic              r_cur;       // buffer holding the word now being streamed
  logic              r_dst;       // buffer the in-flight read lands in
  logic              r_inflight;  // a prefetch read was issued last cycle
  logic              r_issued;    // prefetch for the current word end already sent
  logic              w_issue;
  logic [ADDR_W-1:0] w_next_addr;
`else
  logic [WORD_W-1:0] r_buf;
`endif

  // N is irrelevant to the readout; keep it visibly consumed
  assign w_unused_n = ^MNT[7:4];

  // Dimensions above MAX_DIM are clamped at capture time
  assign w_m_clamp = (MNT[11:8] > 4'(MAX_DIM)) ? 4'(MAX_DIM) : MNT[11:8];
  assign w_t_clamp = (MNT[3:0]  > 4'(MAX_DIM)) ? 4'(MAX_DIM) : MNT[3:0];

  assign w_hs       = (r_state == S_SEND) && OUT_READY;
  assign w_row_end  = (r_col == r_t - 4'd1);
  assign w_word_end = w_row_end || (r_col[1:0] == 2'd3);
  assign w_last     = w_row_end && (r_row == r_m - 4'd1);

`ifdef RESULT_READER_PREFETCH_EN
  // A word whose read is still in flight is presented straight from the SRAM bus
  assign w_word = (r_inflight && (r_dst == r_cur)) ? RDATA_O : r_buf[r_cur];
  // Next word: first word of the next row, or the upper half of this row
  assign w_next_addr = w_row_end ? 4'({r_row[2:0], 1'b0} + 4'd2) : {r_row[2:0], 1'b1};
`else
  assign w_word = r_buf;
`endif

  // Column c lives in bits [63-16*(c%4) -: 16]
  assign w_elem = w_word[{~r_col[1:0], 4'b0000} +: ELEM_W];

  assign RW_O = 1'b0;

  // State register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_state_next = r_state;
    EN_O         = 1'b0;
    ADDR_O       = '0;
    OUT_VALID    = 1'b0;
    OUT_DATA     = '0;
    OUT_LAST     = 1'b0;
    BUSY         = 1'b0;
    DONE         = 1'b0;
`ifdef RESULT_READER_PREFETCH_EN
    w_issue      = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_state_next = ((w_m_clamp == 4'd0) || (w_t_clamp == 4'd0)) ? S_SKIP : S_RD;
        end
      end
      S_SKIP: begin
        BUSY         = 1'b1;
        w_state_next = S_FIN;
      end
      S_RD: begin
        BUSY         = 1'b1;
        EN_O         = 1'b1;
        ADDR_O       = {r_row[2:0], r_col[2]};
        w_state_next = S_WT;
      end
      S_WT: begin
        BUSY         = 1'b1;
        w_state_next = S_SEND;
      end
      S_SEND: begin
        BUSY      = 1'b1;
        OUT_VALID = 1'b1;
        OUT_DATA  = w_elem;
        OUT_LAST  = w_last;
`ifdef RESULT_READER_PREFETCH_EN
        if (w_word_end && !w_last && !r_issued) begin
          w_issue = 1'b1;
          EN_O    = 1'b1;
          ADDR_O  = w_next_addr;
        end
        if (w_hs && w_last) begin
          w_state_next = S_FIN;
        end
`else
        if (w_hs) begin
          if (w_last) begin
            w_state_next = S_FIN;
          end else if (w_word_end) begin
            w_state_next = S_RD;
          end
        end
`endif
      end
      S_FIN: begin
        DONE         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Dimension capture, row/col walk and word buffering
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_m        <= '0;
      r_t        <= '0;
      r_row      <= '0;
      r_col      <= '0;
`ifdef RESULT_READER_PREFETCH_EN
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_cur      <= 1'b0;
      r_dst      <= 1'b0;
      r_inflight <= 1'b0;
      r_issued   <= 1'b0;
`else
      r_buf      <= '0;
`endif
    end else begin
      if ((r_state == S_IDLE) && START) begin
        r_m      <= w_m_clamp;
        r_t      <= w_t_clamp;
        r_row    <= '0;
        r_col    <= '0;
`ifdef RESULT_READER_PREFETCH_EN
        r_cur    <= 1'b0;
        r_issued <= 1'b0;
`endif
      end
      if (w_hs && !w_last) begin
        if (w_row_end) begin
          r_col <= '0;
          r_row <= r_row + 4'd1;
        end else begin
          r_col <= r_col + 4'd1;
        end
      end
`ifdef RESULT_READER_PREFETCH_EN
      if (r_state == S_WT) begin
        r_buf[r_cur] <= RDATA_O;
      end
      r_inflight <= w_issue;
      if (w_issue) begin
        r_dst <= ~r_cur;
      end
      if (r_inflight) begin
        r_buf[r_dst] <= RDATA_O;
      end
      if (w_hs && w_word_end) begin
        r_cur    <= ~r_cur;
        r_issued <= 1'b0;
      end else if (w_issue) begin
        r_issued <= 1'b1;
      end
`else
      if (r_state == S_WT) begin
        r_buf <= RDATA_O;
      end
`endif
    end
  end

endmodule

// File: tb/tb_result_reader.sv
// tb_result_reader: randomized self-checking bench for result_reader.
// The expected stream is built from the matrix layout rules directly:
// element (r,c) = 16-bit slice (c%4) of word 2r + c/4, column 0 in the MSBs.
module tb_result_reader;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [11:0] MNT;
  logic        START;
  logic        EN_O;
  logic        RW_O;
  logic [3:0]  ADDR_O;
  logic [63:0] RDATA_O;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [15:0] OUT_DATA;
  logic        OUT_LAST;
  logic        BUSY;
  logic        DONE;

  logic [63:0] mem [16];
  int          n_tests = 0;
  int          n_fail  = 0;

  localparam int LIMIT = 3000;

  result_reader dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .MNT       (MNT),
    .START     (START),
    .EN_O      (EN_O),
    .RW_O      (RW_O),
    .ADDR_O    (ADDR_O),
    .RDATA_O   (RDATA_O),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_LAST  (OUT_LAST),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always #5 CLK = ~CLK;

  // Output SRAM: synchronous read, data valid the cycle after EN_O
  always @(posedge CLK) begin
    if (EN_O && !RW_O) RDATA_O <= mem[ADDR_O];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int clampd(input int v);
    return (v > 8) ? 8 : v;
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_en"},    EN_O,      1'b0);
    chk({tag, "_rw"},    RW_O,      1'b0);
    chk({tag, "_addr"},  ADDR_O,    4'd0);
    chk({tag, "_valid"}, OUT_VALID, 1'b0);
    chk({tag, "_data"},  OUT_DATA,  16'd0);
    chk({tag, "_last"},  OUT_LAST,  1'b0);
    chk({tag, "_busy"},  BUSY,      1'b0);
    chk({tag, "_done"},  DONE,      1'b0);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
  endtask

  // One readout transaction. abort_after > 0 pulls RSTN low after that handshake.
  task automatic run(input logic [11:0] mnt, input int ready_pct, input int abort_after);
    logic [15:0] exp_q[$];
    logic [15:0] exp_mask;
    logic [15:0] seen_mask;
    logic [63:0] w;
    logic [15:0] e;
    logic [15:0] prev_data;
    logic        prev_last;
    bit          prev_pend;
    bit          aborted;
    bit          ready;
    int m, t, n_el, nwords, idx, exp_edges;
    int rd_cnt, hs_cnt, first_k, last_k, done_k, k, rw_bad, extra_done;

    exp_mask = '0; seen_mask = '0; prev_pend = 0; aborted = 0;
    prev_data = '0; prev_last = 1'b0;
    rd_cnt = 0; hs_cnt = 0; first_k = -1; last_k = -1; done_k = -1;
    rw_bad = 0; extra_done = 0;

    // Reference model: row-major walk of the clamped matrix
    m = clampd(int'(mnt[11:8]));
    t = clampd(int'(mnt[3:0]));
    n_el = m * t;
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < t; c++) begin
        idx = 2 * r + c / 4;
        w = mem[idx];
        exp_q.push_back(16'(w >> (48 - 16 * (c % 4))));
        exp_mask[idx] = 1'b1;
      end
    end
    nwords = $countones(exp_mask);
`ifdef RESULT_READER_PREFETCH_EN
    exp_edges = n_el + 3;
`else
    exp_edges = n_el + 1 + 2 * nwords;
`endif

    @(negedge CLK);
    MNT = mnt; START = 1'b1; OUT_READY = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    MNT = 12'($urandom);
    k = 1;
    while (done_k < 0 && !aborted && k <= LIMIT) begin
      if (EN_O) begin
        rd_cnt++;
        seen_mask[ADDR_O] = 1'b1;
      end
      if (RW_O) rw_bad++;
      if (k == 1) chk("busy_after_start", BUSY, 1'b1);
      if (prev_pend) begin
        chk("stall_valid", OUT_VALID, 1'b1);
        chk("stall_data", OUT_DATA, prev_data);
        chk("stall_last", OUT_LAST, prev_last);
      end
      if (OUT_VALID && first_k < 0) first_k = k;
      if (DONE) begin
        done_k = k;
        chk("busy_at_done", BUSY, 1'b0);
      end else begin
        START = (k == 4);  // ignored: block is busy
        ready = ($urandom_range(99) < ready_pct);
        OUT_READY = ready;
        if (OUT_VALID && ready) begin
          hs_cnt++;
          last_k = k;
          if (exp_q.size() == 0) begin
            chk("extra_element", hs_cnt, n_el);
          end else begin
            e = exp_q.pop_front();
            chk("data", OUT_DATA, e);
            chk("last_flag", OUT_LAST, exp_q.size() == 0);
          end
          if (hs_cnt == abort_after) aborted = 1;
        end
        prev_pend = OUT_VALID && !ready;
        prev_data = OUT_DATA;
        prev_last = OUT_LAST;
        @(negedge CLK);
        k++;
      end
    end
    START = 1'b0;
    OUT_READY = 1'b0;

    if (aborted) begin
      RSTN = 1'b0;
      #1;
      check_reset_values("abort_rst");
      repeat (3) begin
        @(negedge CLK);
        if (DONE) extra_done++;
      end
      check_reset_values("abort_hold");
      RSTN = 1'b1;
      repeat (2) begin
        @(negedge CLK);
        if (DONE) extra_done++;
      end
      chk("no_done_after_abort", extra_done, 0);
      $display("[TB] run mnt=%03h aborted after %0d elements", mnt, hs_cnt);
      return;
    end

    chk("done_seen", done_k >= 0, 1'b1);
    repeat (2) begin
      @(negedge CLK);
      if (DONE) extra_done++;
      if (EN_O) rd_cnt++;
    end
    chk("done_single_pulse", extra_done, 0);
    chk("element_count", hs_cnt, n_el);
    chk("addr_set", seen_mask, exp_mask);
    chk("read_count", rd_cnt, nwords);
    chk("rw_always_read", rw_bad, 0);
    if (n_el == 0) begin
      chk("zero_done_cycle", done_k, 2);
      chk("zero_no_valid", first_k, -1);
    end else begin
      chk("first_valid_cycle", first_k, 3);
      chk("done_after_last", done_k, last_k + 1);
      if (ready_pct >= 100) chk("last_handshake_cycle", last_k + 1, exp_edges);
    end
    $display("[TB] run mnt=%03h M=%0d T=%0d ready=%0d%% elements=%0d reads=%0d done_cycle=%0d",
             mnt, m, t, ready_pct, hs_cnt, rd_cnt, done_k);
  endtask

  initial begin
    logic [11:0] mnt_r;
    int          pct_r;

    RSTN = 1'b0; START = 1'b0; MNT = '0; OUT_READY = 1'b0;
    randomize_mem();
    repeat (3) @(negedge CLK);
    check_reset_values("reset");
    RSTN = 1'b1;
    @(negedge CLK);

    mem[0] = 64'h0001_0002_0003_0004;
    run(12'h404, 100, 0);
    mem[1] = 64'h0005_0006_FFFF_FFFF;
    run(12'h206, 100, 0);
    run(12'h206, 30, 0);
    run(12'h040, 100, 0);
    run(12'h00F, 100, 0);
    randomize_mem();
    run(12'hF0F, 100, 0);
    run(12'hF0F, 30, 0);
    run(12'h404, 100, 5);
    randomize_mem();
    run(12'h101, 100, 0);
    run(12'h801, 100, 0);

    for (int i = 0; i < 10; i++) begin
      randomize_mem();
      mnt_r = 12'($urandom);
      case ($urandom_range(2))
        0: pct_r = 30;
        1: pct_r = 70;
        default: pct_r = 100;
      endcase
      run(mnt_r, pct_r, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
